payload_receiver: RTL and testbench
===================================

Name: payload_receiver

Overview:
- Receive-side counterpart of the packet transmitter on the host UART link.
- Consumes bytes from the UART receiver and hunts for a one-byte event code header.
- Collects the fixed-length payload that follows the header and presents it as one wide buffer, with a one-cycle completion pulse.
- Aborts a partial packet on inter-byte timeout.

Parameters:
- EVENT_CODE, 8'hAD, header byte that opens a packet.
- RECV_BYTES_QTD, 41, number of payload bytes after the header (1..63).
- MSB_FIRST, 1, 1: first payload byte lands in the top byte of the buffer; 0: first payload byte lands in bits [7:0].
- TIMEOUT_CICLOS, 50000, maximum idle clocks between bytes while a packet is open (>=2).

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- dado_valido  input  1  one byte strobe from the UART receiver; every high cycle counts as one byte.
- dado_entrada  input  8  received byte, sampled when dado_valido=1.
- buffer_recebido  output  RECV_BYTES_QTD*8  last complete payload; holds its value between packets.
- recepcao_concluida  output  1  one-cycle pulse when buffer_recebido has been updated.
- erro_recepcao  output  1  one-cycle pulse on timeout abort (or checksum failure, see feature).
- ocupado  output  1  high while a packet is open, i.e. after the header and before the packet completes or aborts.

Behaviour:
- Reset, asynchronous: buffer_recebido=0, recepcao_concluida=0, erro_recepcao=0, ocupado=0, state=S_ESPERA_CODIGO, index=0, timeout counter=0.
- Shadow register: RECV_BYTES_QTD*8 bits, internal. buffer_recebido changes only on packet completion, never with partial data.
- S_ESPERA_CODIGO:
  - dado_valido with dado_entrada==EVENT_CODE: go to S_RECEBE_PAYLOAD, index=0, counter=0, ocupado=1 from next cycle.
  - Any other byte is silently discarded, with no error.
- S_RECEBE_PAYLOAD:
  - On dado_valido, store the byte at slot index. MSB_FIRST=1 writes bits [(RECV_BYTES_QTD-index)*8-1 -: 8]; MSB_FIRST=0 writes bits [index*8 +: 8].
  - On dado_valido, clear the counter and increment index.
  - A byte equal to EVENT_CODE inside the payload is data; there is no resync.
  - Last byte (index==RECV_BYTES_QTD-1 with dado_valido):
    - On that same edge, buffer_recebido <= shadow with the final byte merged.
    - recepcao_concluida=1 for exactly the next cycle.
    - Return to S_ESPERA_CODIGO; ocupado=0 from the next cycle.
    - Latency from the final byte strobe to the pulse is 1 clock.
    - No dead cycle: a header on the very next cycle is accepted.
  - No dado_valido: counter increments. At counter==TIMEOUT_CICLOS-1:
    - erro_recepcao pulses 1 cycle.
    - Partial data is dropped; buffer_recebido is unchanged.
    - Return to S_ESPERA_CODIGO.
- Timeout counter:
  - Runs only in S_RECEBE_PAYLOAD; width is $clog2(TIMEOUT_CICLOS)+1.
  - A byte arriving on the same cycle the counter reaches its limit wins: no timeout, byte accepted.
- Index width: 6 bits.
- recepcao_concluida and erro_recepcao are never high in the same cycle.
- Reset asserted mid-packet: immediate return to reset values. buffer_recebido is cleared, and the aborted packet raises no pulse.
- Any illegal state encoding: go to S_ESPERA_CODIGO.

Optional Feature:
- Macro: PAYLOAD_CHECKSUM_EN.
- Defined:
  - One extra trailing byte follows the payload: the XOR of all RECV_BYTES_QTD payload bytes. The header is excluded.
  - Adds state S_CHECKSUM after the last payload byte, subject to the same timeout.
  - Match: buffer_recebido updated, plus the recepcao_concluida pulse, 1 clock after the checksum byte.
  - Mismatch: buffer_recebido unchanged, erro_recepcao pulses 1 cycle.
- Undefined: no checksum byte and no S_CHECKSUM; completion occurs on the last payload byte as described above.

Test Plan:
- Payload ordering (RECV_BYTES_QTD=4, MSB_FIRST=1): send AD,11,22,33,44 -> buffer_recebido=32'h11223344. recepcao_concluida high exactly 1 cycle, the clock after the 44 strobe. ocupado high from after AD until that pulse.
- Reverse ordering (MSB_FIRST=0): same bytes -> buffer_recebido=32'h44332211.
- Header hunt and embedded code (N=4):
  - Send 00,FF,AA,AD,AD,01,02,03 -> the first three bytes are ignored with no error pulse.
  - Result: buffer_recebido=32'hAD010203.
- Timeout (TIMEOUT_CICLOS=100):
  - AD,11 then 100 idle cycles -> erro_recepcao pulses once, buffer_recebido keeps its prior value.
  - A byte exactly at cycle 99 is accepted instead of timing out.
  - A following full packet AD,01,02,03,04 completes normally.
- Reset mid-packet: AD,11,22, assert reset 1 cycle, then AD,55,66,77,88 -> buffer_recebido=32'h55667788, no error pulse.
- Back-to-back packets and checksum:
  - Two packets with the second header on the cycle after the first's last byte -> two completion pulses, both buffers correct.
  - With PAYLOAD_CHECKSUM_EN, AD,01,02,03,04,04 -> completion; checksum 05 instead -> erro_recepcao, buffer unchanged.

Source files
------------

// File: rtl/payload_receiver.sv
// payload_receiver: hunts for an event-code header on the UART byte stream and collects a fixed-length payload into a wide buffer.
// Build option PAYLOAD_CHECKSUM_EN: adds an XOR checksum byte after the payload.
module payload_receiver #(
  parameter logic [7:0] EVENT_CODE     = 8'hAD,
  parameter int         RECV_BYTES_QTD = 41,
  parameter bit         MSB_FIRST      = 1'b1,
  parameter int         TIMEOUT_CICLOS = 50000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        dado_valido,
  input  logic [7:0]                  dado_entrada,
  output logic [RECV_BYTES_QTD*8-1:0] buffer_recebido,
  output logic                        recepcao_concluida,
  output logic                        erro_recepcao,
  output logic                        ocupado
);
  localparam int W = RECV_BYTES_QTD * 8;
  localparam int CW = $clog2(TIMEOUT_CICLOS) + 1;
  localparam logic [5:0] LAST = 6'(RECV_BYTES_QTD - 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CICLOS - 1);
  typedef enum logic [1:0] {
    S_ESPERA_CODIGO,
    S_RECEBE_PAYLOAD
`ifdef PAYLOAD_CHECKSUM_EN
    , S_CHECKSUM
`endif
  } state_t;
  state_t state_q, state_d;
  logic [5:0] idx_q, idx_d, slot;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] shadow_q, shadow_d, buf_q, buf_d, placed;
  logic done_q, done_d, err_q, err_d, timeout;
`ifdef PAYLOAD_CHECKSUM_EN
  logic [7:0] chk_q, chk_d;
`endif
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    shadow_d = shadow_q;
    buf_d = buf_q;
    done_d = 1'b0;
    err_d = 1'b0;
`ifdef PAYLOAD_CHECKSUM_EN
    chk_d = chk_q;
`endif
    slot = MSB_FIRST ? LAST - idx_q : idx_q;
    placed = shadow_q;
    for (int i = 0; i < RECV_BYTES_QTD; i++)
      if (slot == 6'(i)) placed[i*8 +: 8] = dado_entrada;
    // an arriving byte always beats the timeout on the same cycle
    timeout = !dado_valido && cnt_q == LIMIT;
    case (state_q)
      S_ESPERA_CODIGO: begin
        cnt_d = '0;
        idx_d = '0;
        if (dado_valido && dado_entrada == EVENT_CODE) begin
          state_d = S_RECEBE_PAYLOAD;
`ifdef PAYLOAD_CHECKSUM_EN
          chk_d = '0;
`endif
        end
      end
      S_RECEBE_PAYLOAD: begin
        if (dado_valido) begin
          shadow_d = placed;
          cnt_d = '0;
          idx_d = idx_q + 6'd1;
`ifdef PAYLOAD_CHECKSUM_EN
          chk_d = chk_q ^ dado_entrada;
          if (idx_q == LAST) state_d = S_CHECKSUM;
`else
          if (idx_q == LAST) begin
            state_d = S_ESPERA_CODIGO;
            buf_d = placed;
            done_d = 1'b1;
          end
`endif
        end else if (timeout) begin
          state_d = S_ESPERA_CODIGO;
          err_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
`ifdef PAYLOAD_CHECKSUM_EN
      S_CHECKSUM: begin
        if (dado_valido) begin
          state_d = S_ESPERA_CODIGO;
          buf_d = dado_entrada == chk_q ? shadow_q : buf_q;
          done_d = dado_entrada == chk_q;
          err_d = dado_entrada != chk_q;
        end else if (timeout) begin
          state_d = S_ESPERA_CODIGO;
          err_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
`endif
      default: state_d = S_ESPERA_CODIGO;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= S_ESPERA_CODIGO;
      idx_q <= '0;
      cnt_q <= '0;
      shadow_q <= '0;
      buf_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
`ifdef PAYLOAD_CHECKSUM_EN
      chk_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      shadow_q <= shadow_d;
      buf_q <= buf_d;
      done_q <= done_d;
      err_q <= err_d;
`ifdef PAYLOAD_CHECKSUM_EN
      chk_q <= chk_d;
`endif
    end
  assign buffer_recebido = buf_q;
  assign recepcao_concluida = done_q;
  assign erro_recepcao = err_q;
`ifdef PAYLOAD_CHECKSUM_EN
  assign ocupado = state_q == S_RECEBE_PAYLOAD || state_q == S_CHECKSUM;
`else
  assign ocupado = state_q == S_RECEBE_PAYLOAD;
`endif
endmodule

// File: tb/tb_payload_receiver.sv
// tb_payload_receiver: scoreboard bench driving MSB-first and LSB-first receivers with the same byte stream.
module tb_payload_receiver;
  logic clk = 1'b0, rst = 1'b1, dv = 1'b0;
  logic [7:0] din = 8'h00;
  logic [31:0] buf_m, buf_l;
  logic done_m, err_m, busy_m, done_l, err_l, busy_l;
  typedef struct {
    bit          err;
    logic [31:0] m;
    logic [31:0] l;
    int          cyc;
  } ev_t;
  ev_t q[$];
  ev_t e;
  int total = 0, bad = 0, cyc = 0;
  logic busy_exp = 1'b0;
  logic [31:0] exp_m = '0, exp_l = '0;
  always #5 clk = ~clk;
  payload_receiver #(.EVENT_CODE(8'hAD), .RECV_BYTES_QTD(4), .MSB_FIRST(1'b1), .TIMEOUT_CICLOS(100)) u_msb (
    .clock(clk), .reset(rst), .dado_valido(dv), .dado_entrada(din),
    .buffer_recebido(buf_m), .recepcao_concluida(done_m), .erro_recepcao(err_m), .ocupado(busy_m));
  payload_receiver #(.EVENT_CODE(8'hAD), .RECV_BYTES_QTD(4), .MSB_FIRST(1'b0), .TIMEOUT_CICLOS(100)) u_lsb (
    .clock(clk), .reset(rst), .dado_valido(dv), .dado_entrada(din),
    .buffer_recebido(buf_l), .recepcao_concluida(done_l), .erro_recepcao(err_l), .ocupado(busy_l));
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    chk("ocupado_msb", 64'(busy_m), 64'(busy_exp));
    chk("ocupado_lsb", 64'(busy_l), 64'(busy_exp));
    chk("pulses_lsb_vs_msb", 64'({done_l, err_l}), 64'({done_m, err_m}));
    if (done_m || err_m) begin
      if (q.size() == 0) chk("unexpected_pulse", 64'({done_m, err_m}), 64'(0));
      else begin
        e = q.pop_front();
        chk("pulse_kind", 64'({done_m, err_m}), e.err ? 64'(2'b01) : 64'(2'b10));
        chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
        chk("buffer_msb", 64'(buf_m), 64'(e.m));
        chk("buffer_lsb", 64'(buf_l), 64'(e.l));
      end
    end
  end
  task automatic put(input logic v, input logic [7:0] b);
    dv = v;
    din = b;
    @(posedge clk);
    #1;
    dv = 1'b0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put(1'b0, 8'h00);
  endtask
  task automatic expect_ev(input bit err);
    ev_t x;
    x.err = err;
    x.m = exp_m;
    x.l = exp_l;
    x.cyc = cyc;
    q.push_back(x);
  endtask
  task automatic header();
    put(1'b1, 8'hAD);
    busy_exp = 1'b1;
  endtask
  task automatic finish_pkt(input logic [31:0] p);
`ifdef PAYLOAD_CHECKSUM_EN
    put(1'b1, p[31:24] ^ p[23:16] ^ p[15:8] ^ p[7:0]);
`endif
    exp_m = p;
    exp_l = {p[7:0], p[15:8], p[23:16], p[31:24]};
    expect_ev(1'b0);
    busy_exp = 1'b0;
  endtask
  task automatic pkt(input logic [31:0] p);
    header();
    for (int i = 3; i >= 0; i--) put(1'b1, p[i*8 +: 8]);
    finish_pkt(p);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_buffer_msb", 64'(buf_m), 64'(0));
    chk("reset_buffer_lsb", 64'(buf_l), 64'(0));
    chk("reset_pulses", 64'({done_m, err_m, done_l, err_l}), 64'(0));
    rst = 1'b0;
    idle(2);
    pkt(32'h11223344);
    idle(3);
    put(1'b1, 8'h00);
    put(1'b1, 8'hFF);
    put(1'b1, 8'hAA);
    pkt(32'hAD010203);
    idle(2);
    header();
    put(1'b1, 8'h11);
    idle(99);
    put(1'b1, 8'h22);
    put(1'b1, 8'h33);
    put(1'b1, 8'h44);
    finish_pkt(32'h11223344);
    idle(2);
    header();
    put(1'b1, 8'h11);
    idle(100);
    expect_ev(1'b1);
    busy_exp = 1'b0;
    idle(2);
    pkt(32'h01020304);
    idle(2);
    header();
    put(1'b1, 8'h11);
    put(1'b1, 8'h22);
    rst = 1'b1;
    busy_exp = 1'b0;
    exp_m = '0;
    exp_l = '0;
    #1;
    chk("async_reset_buffer_msb", 64'(buf_m), 64'(0));
    chk("async_reset_buffer_lsb", 64'(buf_l), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    pkt(32'h55667788);
    pkt(32'hCAFEBABE);
    pkt(32'h0A0B0C0D);
`ifdef PAYLOAD_CHECKSUM_EN
    idle(2);
    pkt(32'h01020304);
    header();
    put(1'b1, 8'h01);
    put(1'b1, 8'h02);
    put(1'b1, 8'h03);
    put(1'b1, 8'h04);
    put(1'b1, 8'h05);
    expect_ev(1'b1);
    busy_exp = 1'b0;
`endif
    idle(5);
    chk("missing_pulses", 64'(q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
